// File: rtl/digit_dialer_ctrl_pkg.sv
// Shared types and constants for the digit dialer controller and its digit store.
package digit_dialer_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_GAP     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam int unsigned BCD_MAX = 9;
    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/digit_store.sv
// NUM_DIGITS x BCD register file with a guarded write port and an asynchronous read port.
// Rejected writes (bad slot, non-BCD value or not allowed) raise a one-cycle wr_err.
module digit_store
    import digit_dialer_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_allow,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [3:0] rd_digit_c,
    output logic       wr_err
);

    localparam int unsigned AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [3:0] mem [NUM_DIGITS];
    logic       addr_ok_c;
    logic       wr_ok_c;

    assign addr_ok_c = {1'b0, wr_addr} < 5'(NUM_DIGITS);
    assign wr_ok_c   = wr_allow && addr_ok_c && (wr_data <= 4'(BCD_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_err <= 1'b0;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                mem[i] <= '0;
            end
        end else begin
            wr_err <= wr_en && !wr_ok_c;
            if (wr_en && wr_ok_c) begin
                mem[wr_addr[AW-1:0]] <= wr_data;
            end
        end
    end

    // Out-of-range reads return zero rather than indexing past the array.
    assign rd_digit_c = ({1'b0, rd_addr} < 5'(NUM_DIGITS)) ? mem[rd_addr[AW-1:0]] : 4'd0;

endmodule

// File: rtl/digit_dialer_ctrl.sv
// Plays the stored BCD digits out over a valid/ready handshake with a fixed
// inter-digit gap; supports abort and reports busy, done and rejected writes.
module digit_dialer_ctrl
    import digit_dialer_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 10,
    parameter int unsigned GAP_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       start,
    input  logic       abort,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic [3:0] out_index,
    output logic       busy,
    output logic       done,
    output logic       wr_err
);

    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    state_t          state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_inc_c;
    logic [GW-1:0]   gap_cnt;
    logic [3:0]      rd_addr_c;
    logic [3:0]      rd_digit_c;

    assign idx_inc_c = idx + IW'(1);

    // Read address is the slot that will be presented on the next edge.
    always_comb begin
        rd_addr_c = 4'(idx);
        case (state)
            S_IDLE:    rd_addr_c = 4'd0;
            S_PRESENT: rd_addr_c = 4'(idx_inc_c);
            default:   rd_addr_c = 4'(idx);
        endcase
    end

    digit_store #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_store (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_allow   (state == S_IDLE),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr_c),
        .rd_digit_c (rd_digit_c),
        .wr_err     (wr_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            gap_cnt   <= '0;
            out_valid <= 1'b0;
            out_digit <= 4'd0;
            out_index <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state     <= S_PRESENT;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_digit <= rd_digit_c;
                        out_index <= 4'd0;
                        busy      <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            state     <= S_DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx <= idx_inc_c;
                            if (GAP_CYCLES == 0) begin
                                out_digit <= rd_digit_c;
                                out_index <= 4'(idx_inc_c);
                            end else begin
                                state     <= S_GAP;
                                gap_cnt   <= GW'(GAP_CYCLES);
                                out_valid <= 1'b0;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (gap_cnt == GW'(1)) begin
                        state     <= S_PRESENT;
                        out_valid <= 1'b1;
                        out_digit <= rd_digit_c;
                        out_index <= 4'(idx);
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                S_DONE: begin
                    // done was raised on entry; abort here has the same effect.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_dialer_ctrl.sv
// Bench for digit_dialer_ctrl: a GAP_CYCLES=3 instance (a) and a GAP_CYCLES=0 instance (b),
// checked cycle by cycle against a timeline model of the expected playout.
module tb_digit_dialer_ctrl;

    localparam int N  = 10;
    localparam int GA = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [3:0] wr_data = 4'd0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;
    logic       sel = 1'b0;

    logic       a_valid, a_busy, a_done, a_err;
    logic [3:0] a_digit, a_index;
    logic       b_valid, b_busy, b_done, b_err;
    logic [3:0] b_digit, b_index;

    logic       obs_valid, obs_busy, obs_done, obs_err;
    logic [3:0] obs_digit, obs_index;

    int vectors = 0;
    int miscompares = 0;
    int ref_st [2][16];

    always #5 clk = ~clk;

    digit_dialer_ctrl #(.NUM_DIGITS(N), .GAP_CYCLES(GA)) dut_a (
        .clk(clk), .reset(reset),
        .wr_en(wr_en && !sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start && !sel), .abort(abort), .out_ready(out_ready),
        .out_valid(a_valid), .out_digit(a_digit), .out_index(a_index),
        .busy(a_busy), .done(a_done), .wr_err(a_err)
    );

    digit_dialer_ctrl #(.NUM_DIGITS(N), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset),
        .wr_en(wr_en && sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start && sel), .abort(abort), .out_ready(out_ready),
        .out_valid(b_valid), .out_digit(b_digit), .out_index(b_index),
        .busy(b_busy), .done(b_done), .wr_err(b_err)
    );

    assign obs_valid = sel ? b_valid : a_valid;
    assign obs_digit = sel ? b_digit : a_digit;
    assign obs_index = sel ? b_index : a_index;
    assign obs_busy  = sel ? b_busy  : a_busy;
    assign obs_done  = sel ? b_done  : a_done;
    assign obs_err   = sel ? b_err   : a_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_digit(input bit u, input int addr, input int data);
        bit ok;
        sel = u;
        wr_en = 1'b1;
        wr_addr = 4'(addr);
        wr_data = 4'(data);
        tick();
        wr_en = 1'b0;
        ok = (addr < N) && (data <= 9);
        vectors++;
        if (obs_err !== !ok) begin
            miscompares++;
            $display("FAIL wr_err addr=%0d data=%0d: got %b want %b", addr, data, obs_err, !ok);
        end
        if (ok) ref_st[u][addr] = data;
        tick();
        vectors++;
        if (obs_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_err_width addr=%0d: got %b want 0", addr, obs_err);
        end
    endtask

    task automatic load_random(input bit u, input int lo);
        for (int i = 0; i < N; i++) write_digit(u, i, int'($urandom_range(9, lo)));
    endtask

    // Expected timeline: digit k is due once the previous accept is g+1 cycles old,
    // done follows the last accept by one cycle, abort/reset end the run.
    task automatic run_playout(input bit u, input int ready_pct, input int stall_idx,
                               input int stall_len, input int abort_idx, input bit abort_on_accept,
                               input int reset_idx, input bit wr_busy, output int done_seen);
        int g, rel, due, idx, done_at, stall_left, abort_rel, wr_rel;
        bit exp_valid, exp_busy, exp_done, exp_err, rdy, acc, arm, stopped;
        logic [3:0] exp_d;
        g = u ? 0 : GA;
        sel = u;
        done_seen = -1; due = 1; idx = 0; done_at = -1; stall_left = -1;
        abort_rel = -1; wr_rel = -1; arm = 1'b0; stopped = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (rel = 1; rel < 600 && !stopped; rel++) begin
            exp_valid = (abort_rel < 0) && (idx < N) && (rel >= due);
            exp_done  = (rel == done_at);
            exp_busy  = (abort_rel < 0) && (done_at < 0 || rel <= done_at);
            exp_err   = (wr_rel >= 0) && (rel == wr_rel + 1);
            vectors++;
            if (obs_valid !== exp_valid) begin
                miscompares++;
                $display("FAIL out_valid u=%0d rel=%0d: got %b want %b", u, rel, obs_valid, exp_valid);
            end
            if (exp_valid) begin
                exp_d = 4'(ref_st[u][idx]);
                vectors += 2;
                if (obs_digit !== exp_d) begin
                    miscompares++;
                    $display("FAIL out_digit u=%0d rel=%0d: got %0d want %0d", u, rel, obs_digit, exp_d);
                end
                if (obs_index !== 4'(idx)) begin
                    miscompares++;
                    $display("FAIL out_index u=%0d rel=%0d: got %0d want %0d", u, rel, obs_index, idx);
                end
            end
            vectors += 3;
            if (obs_done !== exp_done) begin
                miscompares++;
                $display("FAIL done u=%0d rel=%0d: got %b want %b", u, rel, obs_done, exp_done);
            end
            if (obs_busy !== exp_busy) begin
                miscompares++;
                $display("FAIL busy u=%0d rel=%0d: got %b want %b", u, rel, obs_busy, exp_busy);
            end
            if (obs_err !== exp_err) begin
                miscompares++;
                $display("FAIL wr_err_busy u=%0d rel=%0d: got %b want %b", u, rel, obs_err, exp_err);
            end
            if (obs_done === 1'b1) done_seen = rel;
            if ((abort_rel >= 0 && rel == abort_rel) || (done_at >= 0 && rel == done_at + 1)) begin
                stopped = 1'b1;
            end else if (reset_idx >= 0 && exp_valid && idx == reset_idx) begin
                reset = 1'b1;
                out_ready = 1'b0;
                tick();
                reset = 1'b0;
                vectors += 6;
                if (obs_valid !== 1'b0 || obs_digit !== 4'd0 || obs_index !== 4'd0 ||
                    obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_mid: got v=%b d=%0d i=%0d b=%b dn=%b e=%b want all 0",
                             obs_valid, obs_digit, obs_index, obs_busy, obs_done, obs_err);
                end
                for (int k = 0; k < 16; k++) begin
                    ref_st[0][k] = 0;
                    ref_st[1][k] = 0;
                end
                stopped = 1'b1;
            end else begin
                wr_en = 1'b0;
                abort = 1'b0;
                if (exp_valid && idx == stall_idx && stall_left < 0) stall_left = stall_len;
                if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else begin
                    rdy = ($urandom_range(99) < 32'(ready_pct));
                end
                out_ready = rdy;
                acc = exp_valid && rdy;
                if (wr_busy && rel == 2) begin
                    wr_en = 1'b1;
                    wr_addr = 4'd9;
                    wr_data = 4'((ref_st[u][9] + 1) % 10);
                    wr_rel = rel;
                end
                if (arm) begin
                    abort = 1'b1;
                    abort_rel = rel + 1;
                    arm = 1'b0;
                end else if (abort_idx >= 0 && abort_on_accept && acc && idx == abort_idx) begin
                    abort = 1'b1;
                    abort_rel = rel + 1;
                end
                if (acc && !abort) begin
                    if (!abort_on_accept && idx == abort_idx) arm = 1'b1;
                    idx++;
                    due = rel + g + 1;
                    if (idx == N) done_at = rel + 1;
                end
                tick();
            end
        end
        vectors++;
        if (!stopped) begin
            miscompares++;
            $display("FAIL playout_timeout u=%0d: got no end in 600 cycles want done or abort", u);
        end
        out_ready = 1'b0;
        abort = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ref_st[0][k] = 0;
            ref_st[1][k] = 0;
        end
        vectors += 7;
        if (a_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", a_valid); end
        if (a_digit !== 4'd0) begin miscompares++; $display("FAIL rst_digit: got %0d want 0", a_digit); end
        if (a_index !== 4'd0) begin miscompares++; $display("FAIL rst_index: got %0d want 0", a_index); end
        if (a_busy !== 1'b0)  begin miscompares++; $display("FAIL rst_busy: got %b want 0", a_busy); end
        if (a_done !== 1'b0)  begin miscompares++; $display("FAIL rst_done: got %b want 0", a_done); end
        if (a_err !== 1'b0)   begin miscompares++; $display("FAIL rst_wr_err: got %b want 0", a_err); end
        if (b_valid !== 1'b0 || b_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_b: got valid=%b busy=%b want 0 0", b_valid, b_busy);
        end
    endtask

    task automatic test_write_errors();
        int pat [N] = '{5, 5, 5, 0, 1, 2, 3, 4, 6, 7};
        for (int i = 0; i < N; i++) write_digit(1'b0, i, pat[i]);
        write_digit(1'b0, 10, 3);
        write_digit(1'b0, 1, 12);
        for (int i = 0; i < 6; i++) begin
            write_digit(1'b0, int'($urandom_range(15, 10)), int'($urandom_range(9)));
            write_digit(1'b0, int'($urandom_range(9)), int'($urandom_range(15, 10)));
        end
    endtask

    task automatic test_playout();
        int ds;
        run_playout(1'b0, 100, -1, 0, -1, 1'b0, -1, 1'b0, ds);
        vectors++;
        if (ds !== 1 + N + (N - 1) * GA) begin
            miscompares++;
            $display("FAIL done_latency: got %0d want %0d", ds, 1 + N + (N - 1) * GA);
        end
    endtask

    task automatic test_back_pressure();
        int ds;
        run_playout(1'b0, 100, 2, 5, -1, 1'b0, -1, 1'b0, ds);
        vectors++;
        if (ds !== 1 + N + (N - 1) * GA + 5) begin
            miscompares++;
            $display("FAIL stall_latency: got %0d want %0d", ds, 1 + N + (N - 1) * GA + 5);
        end
        for (int r = 0; r < 3; r++) begin
            load_random(1'b0, 0);
            run_playout(1'b0, 35 + 20 * r, -1, 0, -1, 1'b0, -1, 1'b0, ds);
        end
    endtask

    task automatic test_abort();
        int ds;
        run_playout(1'b0, 100, -1, 0, 4, 1'b0, -1, 1'b0, ds);
        run_playout(1'b0, 100, -1, 0, -1, 1'b0, -1, 1'b0, ds);
        vectors++;
        if (ds !== 1 + N + (N - 1) * GA) begin
            miscompares++;
            $display("FAIL replay_latency: got %0d want %0d", ds, 1 + N + (N - 1) * GA);
        end
        run_playout(1'b0, 100, -1, 0, N - 1, 1'b1, -1, 1'b0, ds);
        run_playout(1'b0, 60, -1, 0, int'($urandom_range(N - 2)), 1'b0, -1, 1'b0, ds);
    endtask

    task automatic test_write_busy();
        int ds;
        run_playout(1'b0, 100, -1, 0, -1, 1'b0, -1, 1'b1, ds);
    endtask

    task automatic test_reset_mid();
        int ds;
        load_random(1'b0, 1);
        run_playout(1'b0, 100, -1, 0, -1, 1'b0, 6, 1'b0, ds);
        run_playout(1'b0, 100, -1, 0, -1, 1'b0, -1, 1'b0, ds);
    endtask

    task automatic test_gap0();
        int ds;
        load_random(1'b1, 0);
        run_playout(1'b1, 100, -1, 0, -1, 1'b0, -1, 1'b0, ds);
        vectors++;
        if (ds !== 1 + N) begin
            miscompares++;
            $display("FAIL gap0_latency: got %0d want %0d", ds, 1 + N);
        end
        run_playout(1'b1, 50, -1, 0, -1, 1'b0, -1, 1'b0, ds);
        run_playout(1'b1, 100, -1, 0, 3, 1'b0, -1, 1'b0, ds);
    endtask

    initial begin
        test_reset();
        test_write_errors();
        test_playout();
        test_back_pressure();
        test_abort();
        test_write_busy();
        test_reset_mid();
        test_gap0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/digit_dialer_ctrl.md
Name: digit_dialer_ctrl

Overview:
Sequencing controller for the phone-number digit path. It holds a writable NUM_DIGITS-entry BCD digit store. On a start command it plays the stored digits out in order to a downstream consumer (tone generator or 7-segment driver) over a valid/ready handshake, with a programmable inter-digit gap. It supports abort, busy/done status and write-error flagging.

Parameters:
NUM_DIGITS, 10, number of digits in the stored number (2..16)
GAP_CYCLES, 3, idle clocks between an accepted digit and the next presented digit (0 = back-to-back)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
wr_en  in  1  write strobe into digit store
wr_addr  in  4  digit slot index
wr_data  in  4  BCD digit value
start  in  1  begin playout (single-cycle pulse, IDLE only)
abort  in  1  terminate playout
out_ready  in  1  downstream accepts digit
out_valid  out  1  out_digit/out_index valid
out_digit  out  4  current BCD digit
out_index  out  4  slot index of out_digit
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after last digit accepted
wr_err  out  1  one-cycle pulse on a rejected write

Behaviour:
- Reset (synchronous, active-high) values:
  - out_valid=0, out_digit=0, out_index=0, busy=0, done=0, wr_err=0.
  - State=IDLE; all store entries cleared to 0; gap counter=0.
  - Reset mid-playout aborts immediately; no done is produced.
- Store writes:
  - Accepted only in IDLE, with wr_addr<NUM_DIGITS and wr_data<=9.
  - An accepted write updates the entry on the next edge.
  - Otherwise the write is ignored and wr_err pulses on the following cycle.
- Start and abort in IDLE:
  - start in IDLE moves to PRESENT next cycle with index=0.
  - start outside IDLE is ignored silently.
  - start and abort in the same IDLE cycle: abort wins, remain IDLE.
- PRESENT:
  - out_valid=1; out_digit=store[index]; out_index=index.
  - Outputs stay stable until the handshake completes.
  - A write cannot alter them, since writes are blocked while busy.
- Accept (out_valid & out_ready):
  - If index==NUM_DIGITS-1, go to DONE.
  - Else index increments. If GAP_CYCLES>0, go to GAP with counter=GAP_CYCLES; if GAP_CYCLES==0, stay in PRESENT presenting the next digit on the following cycle.
  - The next digit is never presented in the same cycle as an accept.
- GAP:
  - out_valid=0; the counter decrements each cycle.
  - When the counter reaches 1, go to PRESENT. The gap is therefore exactly GAP_CYCLES low cycles.
- DONE:
  - done=1 for one cycle, out_valid=0, busy=1; then IDLE.
- Abort:
  - abort in PRESENT, GAP or DONE goes to IDLE next cycle with out_valid=0 and no done.
  - In DONE, done still asserts in that cycle, because it is already in progress.
  - abort has priority over a simultaneous accept.
- out_digit/out_index outside PRESENT hold their last values (don't-care to consumers); verification checks them only when out_valid=1.
- Widths:
  - Index register is $clog2(NUM_DIGITS) bits, zero-extended to 4.
  - Gap counter is $clog2(GAP_CYCLES+1) bits (min 1); no wrap-around is possible.
- Latency from start to first out_valid: 1 cycle. Minimum full playout with out_ready tied high: 1 + NUM_DIGITS + (NUM_DIGITS-1)*GAP_CYCLES cycles to the done pulse.

Decomposition:
- Shared package: state enum (IDLE, PRESENT, GAP, DONE), BCD_MAX=9 constant, 4-bit digit typedef.
- One sub-module, digit_store: NUM_DIGITS x 4 register file with synchronous clear on reset, gated write port with range/value checks producing wr_err, combinational read port.
- The FSM, index and gap counter remain in digit_dialer_ctrl.

Test Plan:
- Playout, back-pressure free: write digits 5,5,5,0,1,2,3,4,6,7 to slots 0..9, out_ready=1, start pulse.
  - out_valid first at start+1 with digit 5, index 0.
  - Digits appear in order, separated by 3 low cycles.
  - done pulses exactly at cycle start+38; busy is low afterwards.
- Back-pressure: hold out_ready=0 for 5 cycles on index 2 → out_valid, out_digit=5 and out_index=2 stay stable all 5 cycles; index 3 is presented 3 gap cycles after acceptance.
- Abort:
  - Assert abort during GAP after index 4 → IDLE next cycle, no done, busy=0.
  - A new start replays from index 0.
  - abort together with an accept of index 9 → no done.
- Write errors:
  - wr_addr=10, wr_data=3 → wr_err pulse, store unchanged.
  - wr_data=12 → wr_err pulse.
  - Any write while busy → wr_err pulse, and that playout's digits are unchanged.
- Reset mid-playout at index 6 → all outputs 0 next cycle, store reads all zeros; a subsequent start plays ten 0 digits.
- GAP_CYCLES=0 build: consecutive digits are presented on consecutive cycles with out_ready=1; done at start+11.
